otter_lsu: RTL and testbench
============================

// Module: otter_lsu
// PURPOSE
//   CPU-side load/store initiator for the OTTER data port. It accepts one load or store from the
//   execute/mem stage over a valid/ready handshake. It drives the memory wrapper data-port request
//   (MEM_RDEN2/MEM_WE2/MEM_ADDR2/MEM_DIN2/MEM_SIZE/MEM_SIGN) and holds it stable until completion.
//   It returns read data or an error to the pipeline. It serves both the multi-cycle and pipelined OTTER.
// PARAMETERS
//   IO_BASE         32'h0001_0000  first MMIO address; addresses >= IO_BASE take the fixed-latency IO path
//   TIMEOUT_CYCLES  64             watchdog limit in cycles (used only with LSU_TIMEOUT_EN)
// PORTS
//   CLK         in   1   clock
//   RST_N       in   1   asynchronous, active-low reset
//   req_valid   in   1   pipeline request present
//   req_ready   out  1   LSU idle; a request is accepted when req_valid & req_ready
//   req_we      in   1   1 = store, 0 = load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data, unshifted rs2 (memory places the bytes)
//   req_size    in   2   0 = byte, 1 = half, 2 = word
//   req_sign    in   1   1 = unsigned, 0 = signed
//   resp_valid  out  1   one-cycle completion pulse
//   resp_rdata  out  32  load data, already sized/extended by memory; held until the next response
//   resp_err    out  1   valid with resp_valid: misaligned access (or timeout)
//   MEM_RDEN2   out  1   memory read enable
//   MEM_WE2     out  1   memory write enable
//   MEM_ADDR2   out  32  memory address
//   MEM_DIN2    out  32  memory write data
//   MEM_SIZE    out  2   memory access size
//   MEM_SIGN    out  1   memory sign control
//   MEM_DOUT2   in   32  memory read data
//   MEM_VALID2  in   1   memory access complete
//   MEM_ERR     in   1   combinational misalignment flag from memory
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0 except req_ready=1. Every MEM_* output is a register.
//   - IDLE: req_ready=1. On accept, register addr/wdata/size/sign. Next state is ACCESS if addr < IO_BASE, else IO.
//   - ACCESS: assert RDEN2 (load) or WE2 (store), with all MEM_* fields held constant.
//     - If MEM_ERR is high in the first ACCESS cycle: go to RESP with resp_err=1.
//     - On MEM_VALID2: capture MEM_DOUT2 (loads only) and go to RESP.
//     - Otherwise stay in ACCESS; there is no limit without the macro.
//   - IO: enable is asserted for exactly 1 cycle. Next state is IO_WAIT, which captures MEM_DOUT2
//     (the memory's registered IO buffer) for loads and then goes to RESP. MEM_VALID2 is ignored on the IO path.
//   - RESP: enables are 0; resp_valid=1 for one cycle; then IDLE.
//     - This dead cycle guarantees the enables drop between back-to-back accesses.
//   - Latency:
//     - Accept at T; enables at T+1; VALID2 at C; resp_valid at C+1; req_ready at C+2.
//     - IO: resp_valid at T+3.
//   - req_valid while busy: ignored (req_ready=0), and pipeline inputs are not sampled.
//   - Stores: resp_rdata is left unchanged.
//   - Error response: resp_rdata is unchanged, and no enable is asserted after the error cycle.
//   - Reset mid-access: state returns to IDLE and enables drop immediately (asynchronous clear);
//     no response is generated.
// CONFIGURATION
//   - LSU_TIMEOUT_EN defined:
//     - A counter clears on entry to ACCESS and increments each ACCESS cycle.
//     - If it reaches TIMEOUT_CYCLES-1 with no MEM_VALID2: enables drop, RESP with resp_err=1.
//     - If MEM_VALID2 arrives in the same cycle as the limit, VALID2 wins (normal completion).
//   - Undefined: no counter; ACCESS waits indefinitely; resp_err is caused only by MEM_ERR.
// STRUCTURE
//   - otter_lsu_pkg:
//     - lsu_state_t enum {IDLE, ACCESS, IO, IO_WAIT, RESP}
//     - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants
//     - IO_BASE_DEFAULT
//   - Sub-module otter_lsu_watchdog: counter plus compare, instantiated only under LSU_TIMEOUT_EN.
// TESTING
//   1. Load word at 0x100; memory stub returns VALID2 4 cycles after RDEN2, DOUT2=0xDEADBEEF.
//      -> RDEN2 is held for 4 cycles, then resp_valid=1 with rdata=0xDEADBEEF; req_ready returns 1 cycle later.
//   2. Store half at 0x202, wdata=0x1234ABCD.
//      -> WE2=1, ADDR2=0x202, SIZE=1, DIN2=0x1234ABCD, all stable until VALID2; resp_err=0.
//   3. Load word at 0x103 with the stub raising MEM_ERR.
//      -> resp_valid with resp_err=1 two cycles after accept; RDEN2 high for exactly one cycle.
//   4. Load at 0x11000 with DOUT2=0x55 on the cycle after RDEN2.
//      -> RDEN2 is a 1-cycle pulse; resp_rdata=0x55 at T+3 with no VALID2 needed.
//   5. Back-to-back requests with req_valid held high.
//      -> The second request is accepted only in IDLE; a 0 cycle on both enables separates the accesses.
//   6. Assert RST_N low mid-ACCESS.
//      -> Enables are 0 immediately with no resp_valid; with LSU_TIMEOUT_EN, a stub that never sends
//         VALID2 gives resp_err at TIMEOUT_CYCLES+1.

Source files
------------

// File: rtl/otter_lsu_pkg.sv
// otter_lsu_pkg: shared types and constants for the OTTER load/store unit.
//   lsu_state_t      : LSU FSM states
//   SIZE_BYTE/HALF/WORD : encodings of req_size / MEM_SIZE
//   IO_BASE_DEFAULT  : first memory-mapped IO address
//   is_io()          : address decode for the fixed-latency IO path
package otter_lsu_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACCESS  = 3'd1,
      IO      = 3'd2,
      IO_WAIT = 3'd3,
      RESP    = 3'd4
   } lsu_state_t;

   localparam logic [1:0]  SIZE_BYTE       = 2'd0;
   localparam logic [1:0]  SIZE_HALF       = 2'd1;
   localparam logic [1:0]  SIZE_WORD       = 2'd2;
   localparam logic [31:0] IO_BASE_DEFAULT = 32'h0001_0000;

   function automatic logic is_io(input logic [31:0] addr, input logic [31:0] base);
      return addr >= base;
   endfunction

endpackage

// File: rtl/otter_lsu_if.sv
// otter_lsu_if: pipeline request/response channel plus the memory data port.
//   Pipeline side : req_valid/req_ready/req_we/req_addr/req_wdata/req_size/req_sign,
//                   resp_valid/resp_rdata/resp_err
//   Memory side   : MEM_RDEN2/MEM_WE2/MEM_ADDR2/MEM_DIN2/MEM_SIZE/MEM_SIGN (to memory),
//                   MEM_DOUT2/MEM_VALID2/MEM_ERR (from memory)
//   modport master : the LSU (initiator of memory accesses)
//   modport slave  : the environment (pipeline + memory wrapper)
interface otter_lsu_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_sign;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        MEM_RDEN2;
   logic        MEM_WE2;
   logic [31:0] MEM_ADDR2;
   logic [31:0] MEM_DIN2;
   logic [1:0]  MEM_SIZE;
   logic        MEM_SIGN;
   logic [31:0] MEM_DOUT2;
   logic        MEM_VALID2;
   logic        MEM_ERR;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, req_size, req_sign,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN,
      input  MEM_DOUT2, MEM_VALID2, MEM_ERR
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, req_size, req_sign,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN,
      output MEM_DOUT2, MEM_VALID2, MEM_ERR
   );

endinterface

// File: rtl/otter_lsu_watchdog.sv
// otter_lsu_watchdog: cycle counter for a stalled memory access.
//   CLK, RST_N : clock, async active-low reset
//   in_access  : LSU is in ACCESS; counter is held at 0 otherwise, so it is
//                zero on the first ACCESS cycle
//   expired    : count reached TIMEOUT_CYCLES-1 while in ACCESS
module otter_lsu_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic in_access,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)          cnt <= '0;
      else if (!in_access) cnt <= '0;
      else if (cnt != LIMIT) cnt <= cnt + 1'b1;
   end

   assign expired = in_access && (cnt == LIMIT);

endmodule

// File: rtl/otter_lsu.sv
// otter_lsu: CPU-side load/store initiator for the OTTER data port.
//   CLK, RST_N : clock, async active-low reset
//   bus        : otter_lsu_if.master -- pipeline req/resp handshake and the
//                memory data port (all MEM_* outputs are registers)
// Addresses >= IO_BASE use a fixed-latency path (1-cycle enable, data read
// from the memory's registered IO buffer one cycle later). Other addresses
// hold the request until MEM_VALID2 or a first-cycle MEM_ERR.
// Optional build macro LSU_TIMEOUT_EN adds a watchdog that ends a stalled
// ACCESS with resp_err after TIMEOUT_CYCLES cycles.
module otter_lsu
   import otter_lsu_pkg::*;
#(
   parameter logic [31:0]  IO_BASE        = IO_BASE_DEFAULT,
   parameter int unsigned  TIMEOUT_CYCLES = 64
) (
   input  logic        CLK,
   input  logic        RST_N,
   otter_lsu_if.master bus
);

   lsu_state_t state_q, state_d;
   logic       accept;
   logic       first_q;    // first cycle of ACCESS: the only cycle MEM_ERR is honoured
   logic       we_q;
   logic       we_nxt;
   logic       en_d;
   logic       err_now;
   logic       tmo_hit;
   logic       req_ready_c, resp_valid_c;
   logic       resp_err_q;
   logic [31:0] rdata_q;

`ifdef LSU_TIMEOUT_EN
   otter_lsu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_access (state_q == ACCESS),
      .expired   (tmo_hit)
   );
`else
   logic unused_tmo;
   assign unused_tmo = |TIMEOUT_CYCLES;
   assign tmo_hit    = 1'b0;
`endif

   assign accept = bus.req_valid && (state_q == IDLE);

   // state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = is_io(bus.req_addr, IO_BASE) ? IO : ACCESS;
         ACCESS:  if ((first_q && bus.MEM_ERR) || bus.MEM_VALID2 || tmo_hit) state_d = RESP;
         IO:      state_d = IO_WAIT;
         IO_WAIT: state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs decoded from state
   always_comb begin
      req_ready_c  = (state_q == IDLE);
      resp_valid_c = (state_q == RESP);
   end

   // An error ends the access; a VALID2 on the timeout cycle is a normal completion.
   assign err_now = (state_q == ACCESS) &&
                    ((first_q && bus.MEM_ERR) || (tmo_hit && !bus.MEM_VALID2));

   // Enables are registered from the next state. IO is only entered from
   // IDLE, so an enable in IO lasts exactly one cycle.
   assign en_d   = (state_d == ACCESS) || (state_d == IO);
   assign we_nxt = accept ? bus.req_we : we_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus.MEM_RDEN2 <= 1'b0;
         bus.MEM_WE2   <= 1'b0;
         bus.MEM_ADDR2 <= '0;
         bus.MEM_DIN2  <= '0;
         bus.MEM_SIZE  <= '0;
         bus.MEM_SIGN  <= 1'b0;
         we_q          <= 1'b0;
         first_q       <= 1'b0;
         resp_err_q    <= 1'b0;
         rdata_q       <= '0;
      end else begin
         if (accept) begin
            bus.MEM_ADDR2 <= bus.req_addr;
            bus.MEM_DIN2  <= bus.req_wdata;
            bus.MEM_SIZE  <= bus.req_size;
            bus.MEM_SIGN  <= bus.req_sign;
            we_q          <= bus.req_we;
         end
         bus.MEM_RDEN2 <= en_d && !we_nxt;
         bus.MEM_WE2   <= en_d &&  we_nxt;
         first_q       <= (state_d == ACCESS) && (state_q != ACCESS);
         resp_err_q    <= (state_d == RESP) && err_now;
         if (!we_q && ((state_q == IO_WAIT) ||
                       (state_q == ACCESS && bus.MEM_VALID2 && !err_now)))
            rdata_q <= bus.MEM_DOUT2;
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.resp_valid = resp_valid_c;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_otter_lsu.sv
// tb_otter_lsu: directed self-checking bench for otter_lsu (default parameters).
module tb_otter_lsu;
   import otter_lsu_pkg::*;

   logic CLK;
   logic RST_N;
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;

   otter_lsu_if bus ();

   otter_lsu u_dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic sign);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_size  = size;
      bus.req_sign  = sign;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed=hang expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      RST_N          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_size   = SIZE_BYTE;
      bus.req_sign   = 1'b0;
      bus.MEM_DOUT2  = '0;
      bus.MEM_VALID2 = 1'b0;
      bus.MEM_ERR    = 1'b0;

      // ---- reset state
      #3;
      chk("rst_ready",  32'(bus.req_ready),  32'd1);
      chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
      chk("rst_en",     32'({bus.MEM_RDEN2, bus.MEM_WE2}), 32'd0);
      chk("rst_addr",   bus.MEM_ADDR2,  32'd0);
      chk("rst_rdata",  bus.resp_rdata, 32'd0);
      chk("rst_err",    32'(bus.resp_err), 32'd0);
      tick();
      RST_N = 1'b1;
      tick();

      // ---- 1: load word 0x100, VALID2 on the 4th RDEN2 cycle
      drive_req(1'b0, 32'h100, 32'h0, SIZE_WORD, 1'b0);
      tick();                                   // accepted
      bus.req_valid = 1'b0;
      chk("t1_addr", bus.MEM_ADDR2, 32'h100);
      chk("t1_size", 32'(bus.MEM_SIZE), 32'd2);
      chk("t1_busy", 32'(bus.req_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("t1_rden", 32'({bus.MEM_RDEN2, bus.MEM_WE2}), 32'b10);
         tick();
      end
      chk("t1_rden4", 32'(bus.MEM_RDEN2), 32'd1);
      bus.MEM_VALID2 = 1'b1;
      bus.MEM_DOUT2  = 32'hDEAD_BEEF;
      tick();
      bus.MEM_VALID2 = 1'b0;
      bus.MEM_DOUT2  = 32'h0;
      chk("t1_resp",  32'({bus.resp_valid, bus.resp_err}), 32'b10);
      chk("t1_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
      chk("t1_drop",  32'({bus.MEM_RDEN2, bus.req_ready}), 32'b00);
      tick();
      chk("t1_ready", 32'({bus.req_ready, bus.resp_valid}), 32'b10);

      // ---- 2: store half 0x202; inputs changed while busy must not be sampled
      drive_req(1'b1, 32'h202, 32'h1234_ABCD, SIZE_HALF, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'hFFFF_FFF0;
      bus.req_wdata = 32'h0;
      bus.req_size  = SIZE_BYTE;
      for (int i = 0; i < 2; i++) begin
         chk("t2_en",   32'({bus.MEM_RDEN2, bus.MEM_WE2}), 32'b01);
         chk("t2_addr", bus.MEM_ADDR2, 32'h202);
         chk("t2_din",  bus.MEM_DIN2,  32'h1234_ABCD);
         chk("t2_size", 32'(bus.MEM_SIZE), 32'd1);
         if (i == 1) begin
            bus.MEM_VALID2 = 1'b1;
            bus.MEM_DOUT2  = 32'hBAD0_BAD0;
         end
         tick();
      end
      bus.MEM_VALID2 = 1'b0;
      chk("t2_resp",  32'({bus.resp_valid, bus.resp_err, bus.MEM_WE2}), 32'b100);
      chk("t2_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
      tick();

      // ---- 3: misaligned load, MEM_ERR in first ACCESS cycle
      drive_req(1'b0, 32'h103, 32'h0, SIZE_WORD, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      chk("t3_rden", 32'(bus.MEM_RDEN2), 32'd1);
      bus.MEM_ERR   = 1'b1;
      bus.MEM_DOUT2 = 32'h7777_7777;
      tick();
      bus.MEM_ERR   = 1'b0;
      chk("t3_resp",  32'({bus.resp_valid, bus.resp_err}), 32'b11);
      chk("t3_rden0", 32'(bus.MEM_RDEN2), 32'd0);
      chk("t3_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
      tick();
      chk("t3_idle", 32'({bus.MEM_RDEN2, bus.req_ready, bus.resp_err}), 32'b010);

      // ---- 4: IO load at 0x11000, data one cycle after RDEN2, no VALID2
      drive_req(1'b0, 32'h0001_1000, 32'h0, SIZE_WORD, 1'b1);
      tick();
      bus.req_valid = 1'b0;
      chk("t4_rden1", 32'(bus.MEM_RDEN2), 32'd1);
      tick();
      chk("t4_rden0", 32'(bus.MEM_RDEN2), 32'd0);
      bus.MEM_DOUT2 = 32'h55;
      tick();
      bus.MEM_DOUT2 = 32'h0;
      chk("t4_resp",  32'({bus.resp_valid, bus.resp_err}), 32'b10);
      chk("t4_rdata", bus.resp_rdata, 32'h55);
      tick();

      // ---- 5: back-to-back with req_valid held high
      drive_req(1'b0, 32'h300, 32'h0, SIZE_WORD, 1'b0);
      tick();                                   // first accepted
      drive_req(1'b1, 32'h304, 32'hCAFE_F00D, SIZE_WORD, 1'b0);
      chk("t5_rden", 32'({bus.MEM_RDEN2, bus.req_ready}), 32'b10);
      bus.MEM_VALID2 = 1'b1;
      bus.MEM_DOUT2  = 32'h1111_2222;
      tick();                                   // RESP
      bus.MEM_VALID2 = 1'b0;
      chk("t5_gap",   32'({bus.MEM_RDEN2, bus.MEM_WE2, bus.req_ready}), 32'b000);
      chk("t5_rdata", bus.resp_rdata, 32'h1111_2222);
      chk("t5_addr",  bus.MEM_ADDR2, 32'h300);
      tick();                                   // IDLE, second accepted here
      chk("t5_idle",  32'({bus.MEM_RDEN2, bus.MEM_WE2, bus.req_ready}), 32'b001);
      tick();
      bus.req_valid = 1'b0;
      chk("t5_we2",   32'({bus.MEM_RDEN2, bus.MEM_WE2}), 32'b01);
      chk("t5_addr2", bus.MEM_ADDR2, 32'h304);
      chk("t5_din2",  bus.MEM_DIN2,  32'hCAFE_F00D);
      bus.MEM_VALID2 = 1'b1;
      tick();
      bus.MEM_VALID2 = 1'b0;
      chk("t5_resp2", 32'({bus.resp_valid, bus.resp_err}), 32'b10);
      chk("t5_keep",  bus.resp_rdata, 32'h1111_2222);
      tick();

      // ---- 6: reset asserted mid-ACCESS
      drive_req(1'b0, 32'h400, 32'h0, SIZE_WORD, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      tick();
      chk("t6_pre", 32'(bus.MEM_RDEN2), 32'd1);
      #2 RST_N = 1'b0;
      #1;
      chk("t6_en",    32'({bus.MEM_RDEN2, bus.MEM_WE2}), 32'b00);
      chk("t6_state", 32'({bus.req_ready, bus.resp_valid}), 32'b10);
      #2 RST_N = 1'b1;
      begin
         int seen = 0;
         for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.resp_valid) seen++;
         end
         chk("t6_noresp", 32'(seen), 32'd0);
      end

`ifdef LSU_TIMEOUT_EN
      // ---- 6b: watchdog, memory never answers
      drive_req(1'b0, 32'h500, 32'h0, SIZE_WORD, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      begin
         int n = 1;
         while (!bus.resp_valid && n < 200) begin
            tick();
            n++;
         end
         chk("t6_tmo_lat", 32'(n), 32'd65);
         chk("t6_tmo_err", 32'({bus.resp_valid, bus.resp_err, bus.MEM_RDEN2}), 32'b110);
      end
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
